// File: rtl/alu_pkg.sv
// Opcode map shared by the ALU, decoder and multiply/divide sequencer,
// plus the sequencer state type.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] OP_MUL    = 5'b01001;
  localparam logic [ALU_OP_W-1:0] OP_MULH   = 5'b01010;
  localparam logic [ALU_OP_W-1:0] OP_MULHU  = 5'b01011;
  localparam logic [ALU_OP_W-1:0] OP_MULHSU = 5'b01100;
  localparam logic [ALU_OP_W-1:0] OP_DIV    = 5'b01101;
  localparam logic [ALU_OP_W-1:0] OP_DIVU   = 5'b01110;
  localparam logic [ALU_OP_W-1:0] OP_REM    = 5'b01111;
  localparam logic [ALU_OP_W-1:0] OP_REMU   = 5'b10000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mds_state_e;

  function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational multiply (add-shift) or divide (restoring trial-subtract)
// iteration on the {hi, lo} working pair against operand m.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
    shifted = {hi_i, lo_i[XLEN-1]};
    ge      = shifted >= {1'b0, m_i};
    // The partial remainder stays below m, so the subtraction fits in XLEN bits.
    diff    = shifted[XLEN-1:0] - m_i;
    if (div_i) begin
      hi_o = ge ? diff : shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      {hi_o, lo_o} = {sum, lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: one iteration per clock on operand
// magnitudes, sign fixup afterwards, valid/ready on issue and writeback.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OP_W = ALU_OP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] opcode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  mds_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic                nega_q, nega_d, negb_q, negb_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                illegal_q, illegal_d;

  logic [ALU_OP_W-1:0] op_in;
  logic                a_sgn, b_sgn, na, nb, div_in, rem_in, ovf_in;
  logic [XLEN-1:0]     ma, mb, step_hi, step_lo, quo, rmd;
  logic [2*XLEN-1:0]   prod;
  logic                div_q;

  assign op_in  = ALU_OP_W'(opcode);
  assign a_sgn  = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn  = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign na     = a_sgn & a[XLEN-1];
  assign nb     = b_sgn & b[XLEN-1];
  assign ma     = na ? -a : a;
  assign mb     = nb ? -b : b;
  assign div_in = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign rem_in = op_in inside {OP_REM, OP_REMU};
  assign ovf_in = (op_in inside {OP_DIV, OP_REM}) &&
                  (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign div_q  = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_i (div_q),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .m_i   (m_q),
    .hi_o  (step_hi),
    .lo_o  (step_lo)
  );

  // After the iterations: lo holds quotient / low product, hi remainder / high product.
  always_comb begin
    quo  = (nega_q ^ negb_q) ? -lo_q : lo_q;
    rmd  = nega_q ? -hi_q : hi_q;
    prod = (nega_q ^ negb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    nega_d    = nega_q;
    negb_d    = negb_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d      = op_in;
          nega_d    = na;
          negb_d    = nb;
          cnt_d     = '0;
          illegal_d = 1'b0;
          state_d   = DONE;
          if (!is_muldiv(op_in)) begin
            result_d  = '0;
            illegal_d = 1'b1;
          end else if (div_in && (b == '0)) begin
            result_d = rem_in ? a : '1;
          end else if (ovf_in) begin
            result_d = rem_in ? '0 : a;
          end else begin
            hi_d    = '0;
            lo_d    = ma;
            m_d     = mb;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          cnt_d   = '0;
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (div_q) begin
          result_d = (op_q inside {OP_REM, OP_REMU}) ? rmd : quo;
        end else begin
          result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      nega_q    <= 1'b0;
      negb_q    <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      nega_q    <= nega_d;
      negb_q    <= negb_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, hand-written stall/flush/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  opcode = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        illegal;
  logic        busy;

  int tests = 0;
  int failed = 0;

  muldiv_seq #(.XLEN(32), .OP_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1);
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference behaviour from RV32M arithmetic; latency 1 for resolved-at-accept cases.
  function automatic void model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    logic signed [63:0] sx, sy;
    logic [63:0]        ux, uy, p;
    logic signed [31:0] qx, qy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    qx = x;
    qy = y;
    r = '0; ill = 1'b0; lat = 34; p = '0;
    case (op)
      5'b01001: begin p = sx * sy; r = p[31:0];  end
      5'b01010: begin p = sx * sy; r = p[63:32]; end
      5'b01011: begin p = ux * uy; r = p[63:32]; end
      5'b01100: begin p = sx * uy; r = p[63:32]; end
      5'b01101: begin
        if (y == 0) begin r = '1; lat = 1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = x; lat = 1; end
        else r = qx / qy;
      end
      5'b01110: begin
        if (y == 0) begin r = '1; lat = 1; end
        else r = x / y;
      end
      5'b01111: begin
        if (y == 0) begin r = x; lat = 1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = '0; lat = 1; end
        else r = qx % qy;
      end
      5'b10000: begin
        if (y == 0) begin r = x; lat = 1; end
        else r = x % y;
      end
      default: begin ill = 1'b1; lat = 1; end
    endcase
  endfunction

  // Issue one op; lat counts sampling points after the accepting edge until out_valid.
  task automatic do_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       input int stall, output logic [31:0] r, output logic ill, output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    opcode = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    repeat (stall) @(negedge clk);
    r = result; ill = illegal;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check({name, "_no_out_valid"}, {31'b0, seen}, 32'd0);
  endtask

  logic [31:0] pick_val;
  task automatic pick(output logic [31:0] v);
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      default: v = $urandom;
    endcase
  endtask

  vec_t vecs[15];
  logic [31:0] r, er;
  logic        ill, eill;
  int          lat, elat;

  initial begin
    vecs[0]  = '{5'b01001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34};
    vecs[1]  = '{5'b01010, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 34};
    vecs[2]  = '{5'b01011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 34};
    vecs[3]  = '{5'b01100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 34};
    vecs[4]  = '{5'b01101, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0, 34};
    vecs[5]  = '{5'b01111, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0, 34};
    vecs[6]  = '{5'b01110, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 1'b0, 34};
    vecs[7]  = '{5'b10000, 32'hFFFF_FFF9, 32'd2,          32'd1,         1'b0, 34};
    vecs[8]  = '{5'b01101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b0, 1};
    vecs[9]  = '{5'b01111, 32'd5,          32'd0,          32'd5,         1'b0, 1};
    vecs[10] = '{5'b01101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1};
    vecs[11] = '{5'b01111, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1};
    vecs[12] = '{5'b00100, 32'd3,          32'd4,          32'd0,         1'b1, 1};
    vecs[13] = '{5'b01110, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b0, 1};
    vecs[14] = '{5'b01001, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 34};

    // Reset state
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_illegal",   {31'b0, illegal},   32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);

    // Directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, ill, lat);
      check($sformatf("vec%0d_result", i),  r,              vecs[i].res);
      check($sformatf("vec%0d_illegal", i), {31'b0, ill},   {31'b0, vecs[i].ill});
      check($sformatf("vec%0d_latency", i), 32'(lat),       32'(vecs[i].lat));
    end

    // Writeback stall: result held, no new issue, IDLE one cycle after handshake
    opcode = 5'b01001; a = 32'd7; b = 32'hFFFF_FFFD; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    check("stall_latency", 32'(lat), 32'd34);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_result", result, 32'hFFFF_FFEB);
      check("stall_hold", {30'b0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release", {30'b0, out_valid, in_ready}, 32'd1);

    // Flush in BUSY cycle 5
    opcode = 5'b01101; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {29'b0, busy, out_valid, in_ready}, 32'd1);
    wait_quiet("flush", 40);
    do_op(5'b01101, 32'd100, 32'd7, 0, r, ill, lat);
    check("flush_recover_div", r, 32'd14);
    do_op(5'b10000, 32'd100, 32'd7, 0, r, ill, lat);
    check("flush_recover_remu", r, 32'd2);

    // Flush offered together with in_valid is not accepted
    opcode = 5'b01001; a = 32'd3; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {31'b0, busy}, 32'd0);
    wait_quiet("flush_accept", 40);

    // Reset pulse mid-BUSY
    opcode = 5'b01010; a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst_state", {29'b0, busy, out_valid, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_quiet("midrst", 40);
    do_op(5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, ill, lat);
    check("midrst_recover_mulhu", r, 32'hFFFF_FFFE);
    do_op(5'b01001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, ill, lat);
    check("midrst_recover_mul", r, 32'd1);

    // Randomized against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [4:0]  op;
      logic [31:0] x, y;
      if ($urandom_range(0, 15) == 0) op = 5'($urandom_range(0, 31));
      else op = 5'($urandom_range(9, 16));
      pick(x);
      pick(y);
      model(op, x, y, er, eill, elat);
      do_op(op, x, y, $urandom_range(0, 3), r, ill, lat);
      check($sformatf("rnd%0d_op%b_a%h_b%h_result", n, op, x, y), r, er);
      check($sformatf("rnd%0d_illegal", n), {31'b0, ill}, {31'b0, eill});
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
